// File: rtl/carregador_instrucoes.sv
// Loads a program received over UART 8N1 into instruction memory, LSB-first words, holding the core in reset until a zero word lands.
// Optional byte echo on uart_tx when CARREGADOR_ECO_EN is defined.
module carregador_instrucoes #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              rst_core,
  output logic              pronto,
  output logic              erro,
  output logic [ADDR_W:0]   palavras
`ifdef CARREGADOR_ECO_EN
  ,
  output logic              uart_tx
`endif
);
  localparam int CPB  = CLK_HZ / BAUD;
  localparam int MEIO = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);

  typedef enum logic [2:0] {OCIOSO, INICIO, DADOS, PARADA, ESPERA} rx_estado_t;
  typedef enum logic [1:0] {CARGA, PRONTO, ERRO} ld_estado_t;

  logic              r_rx_s1, r_rx_s2;
  rx_estado_t        r_rx_est, w_rx_prox;
  ld_estado_t        r_ld_est, w_ld_prox;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;
  logic [1:0]        r_idx;
  logic [31:0]       r_palavra;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_rst_core, r_pronto, r_erro;
  logic [ADDR_W:0]   r_palavras;
  logic              w_fim_meio, w_fim_bit, w_byte_ok, w_quadro_err;

  assign w_fim_meio = (r_cnt == CW'(MEIO - 1));
  assign w_fim_bit  = (r_cnt == CW'(CPB - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= uart_rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  always_comb begin
    w_rx_prox    = r_rx_est;
    w_byte_ok    = 1'b0;
    w_quadro_err = 1'b0;
    case (r_rx_est)
      OCIOSO: if (!r_rx_s2) w_rx_prox = INICIO;
      INICIO: if (w_fim_meio) w_rx_prox = r_rx_s2 ? OCIOSO : DADOS;
      DADOS:  if (w_fim_bit && r_bit == 3'd7) w_rx_prox = PARADA;
      PARADA: if (w_fim_bit) begin
        if (r_rx_s2) begin
          w_rx_prox = OCIOSO;
          w_byte_ok = 1'b1;
        end else begin
          w_rx_prox    = ESPERA;
          w_quadro_err = 1'b1;
        end
      end
      ESPERA: if (r_rx_s2) w_rx_prox = OCIOSO;
      default: w_rx_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_est <= OCIOSO;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
    end else begin
      r_rx_est <= w_rx_prox;
      // Counter restarts on every state change so each phase times from its own entry.
      if (w_rx_prox != r_rx_est || r_rx_est == OCIOSO || r_rx_est == ESPERA)
        r_cnt <= '0;
      else
        r_cnt <= w_fim_bit ? '0 : r_cnt + 1'b1;
      if (r_rx_est == INICIO)
        r_bit <= '0;
      else if (r_rx_est == DADOS && w_fim_bit) begin
        r_bit   <= r_bit + 1'b1;
        r_shift <= {r_rx_s2, r_shift[7:1]};
      end
    end
  end

  always_comb begin
    w_ld_prox = r_ld_est;
    if (r_ld_est == CARGA && r_we) begin
      if (r_wdata == 32'd0)
        w_ld_prox = PRONTO;
      else if (&r_addr)
        w_ld_prox = ERRO;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ld_est   <= CARGA;
      r_idx      <= '0;
      r_palavra  <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rst_core <= 1'b0;
      r_pronto   <= 1'b0;
      r_erro     <= 1'b0;
      r_palavras <= '0;
    end else begin
      r_ld_est <= w_ld_prox;
      r_we     <= 1'b0;
      if (w_quadro_err) begin
        r_erro <= 1'b1;
        r_idx  <= '0;
      end
      if (w_byte_ok && r_ld_est == CARGA) begin
        r_palavra[{r_idx, 3'b000} +: 8] <= r_shift;
        r_idx <= r_idx + 1'b1;
        if (r_idx == 2'd3) begin
          r_we    <= 1'b1;
          r_wdata <= {r_shift, r_palavra[23:0]};
        end
      end
      if (r_we) begin
        r_addr     <= r_addr + 1'b1;
        r_palavras <= r_palavras + 1'b1;
      end
      if (w_ld_prox == PRONTO && r_ld_est == CARGA) begin
        r_pronto   <= 1'b1;
        r_rst_core <= 1'b1;
      end
      if (w_ld_prox == ERRO && r_ld_est == CARGA)
        r_erro <= 1'b1;
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign rst_core  = r_rst_core;
  assign pronto    = r_pronto;
  assign erro      = r_erro;
  assign palavras  = r_palavras;

`ifdef CARREGADOR_ECO_EN
  logic          r_tx_busy, r_hold_vld;
  logic [9:0]    r_tx_sh;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0]    r_tx_bit;
  logic [7:0]    r_hold;
  logic          w_tx_fim, w_tx_livre;

  assign w_tx_fim   = r_tx_busy && (r_tx_cnt == CW'(CPB - 1)) && (r_tx_bit == 4'd9);
  assign w_tx_livre = !r_tx_busy || w_tx_fim;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx_busy  <= 1'b0;
      r_hold_vld <= 1'b0;
      r_tx_sh    <= '1;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_hold     <= '0;
    end else begin
      // The held byte is older, so it goes out before a byte arriving in the same cycle.
      if (w_tx_livre && (r_hold_vld || w_byte_ok)) begin
        r_tx_busy <= 1'b1;
        r_tx_cnt  <= '0;
        r_tx_bit  <= '0;
        r_tx_sh   <= {1'b1, (r_hold_vld ? r_hold : r_shift), 1'b0};
        r_hold_vld <= r_hold_vld && w_byte_ok;
        if (r_hold_vld && w_byte_ok) r_hold <= r_shift;
      end else begin
        if (w_tx_fim) r_tx_busy <= 1'b0;
        if (w_byte_ok) begin
          r_hold     <= r_shift;
          r_hold_vld <= 1'b1;
        end
        if (r_tx_busy) begin
          if (r_tx_cnt == CW'(CPB - 1)) begin
            r_tx_cnt <= '0;
            r_tx_bit <= r_tx_bit + 1'b1;
            r_tx_sh  <= {1'b1, r_tx_sh[9:1]};
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign uart_tx = r_tx_busy ? r_tx_sh[0] : 1'b1;
`endif
endmodule
